// File: rtl/port_io_unit.sv
// Memory-mapped output FIFO and synchronised input port on the MEM-stage data bus.
// Loads are combinational; writes, pops and input sampling update on the rising edge.
module port_io_unit #(
  parameter logic [31:0] ADDR_BASE  = 32'h1001_0100,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Hit,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic [31:0]   last;
  logic [7:0]    sync1, in_sync, prev;
  logic          chg, ovf;

  logic          empty, full;
  logic          wr_en, out_wr, clr_wr;
  logic          push, pop, drop, chg_set;
  logic [1:0]    reg_sel;
  logic [4:0]    count_ext;
  logic          unused_addr;

  assign unused_addr = ^Address[1:0];

  assign Hit       = (Address[31:4] == ADDR_BASE[31:4]);
  assign reg_sel   = Address[3:2];
  assign empty     = (count == '0);
  assign full      = (count == (PW+1)'(FIFO_DEPTH));
  assign out_valid = !empty;
  assign PortOut   = empty ? 32'h0 : fifo_mem[rd_ptr];
  assign count_ext = 5'(count);

  assign wr_en   = Hit & MemWrite;
  assign out_wr  = wr_en && (reg_sel == 2'd0);
  assign clr_wr  = wr_en && (reg_sel == 2'd2);
  assign pop     = out_valid & out_ready;
  // A pop frees the head slot on the same edge, so a full FIFO still accepts.
  assign push    = out_wr & (!full | pop);
  assign drop    = out_wr & full & !pop;
  assign chg_set = (in_sync != prev);

  always_comb begin
    ReadData = 32'h0;
    if (Hit && MemRead) begin
      case (reg_sel)
        2'd1:    ReadData = {24'h0, in_sync};
        2'd2:    ReadData = {23'h0, count_ext, ovf, chg, full, empty};
        2'd3:    ReadData = last;
        default: ReadData = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= WriteData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      last   <= 32'h0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        last   <= fifo_mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= 8'h0;
      in_sync <= 8'h0;
      prev    <= 8'h0;
      chg     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      sync1   <= PortIn;
      in_sync <= sync1;
      prev    <= in_sync;
      // Sticky flags: a new event outranks a clear arriving in the same cycle.
      if (chg_set) begin
        chg <= 1'b1;
      end else if (clr_wr && WriteData[2]) begin
        chg <= 1'b0;
      end
      if (drop) begin
        ovf <= 1'b1;
      end else if (clr_wr && WriteData[3]) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule
